// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int DEF_ACK_TIMEOUT = 8;

    // One-hot arbiter/sequencer states.
    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        SEND      = 5'b00010,
        WAIT_ACK  = 5'b00100,
        WAIT_DONE = 5'b01000,
        NEXT      = 5'b10000
    } arb_state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or above
// ptr, wrapping past N-1 back to 0.
module uart_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Scan N candidates starting at ptr; the first hit wins.
    always_comb begin
        int unsigned     sum;
        logic [IDX_W-1:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = 32'(ptr) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            cand = IDX_W'(sum);
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ packet sources. Grants are held for a
// whole packet, and the byte is kept on tx_data for the full frame because
// the transmitter does not latch it.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      tx_send,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      err_retry
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  win_onehot;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;

    uart_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (win_onehot),
        .gnt_idx (win_idx),
        .gnt_any (win_any)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic, accept strobes and transmitter handshake.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        data_d    = data_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        tx_send   = 1'b0;
        err_retry = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_done && win_any) begin
                    req_ready = win_onehot;
                    data_d    = req_data[win_idx*DATA_W +: DATA_W];
                    last_d    = req_last[win_idx];
                    grant_d   = win_onehot;
                    owner_d   = win_idx;
                    state_d   = SEND;
                end
            end
            SEND: begin
                tx_send = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!tx_done) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    err_retry = 1'b1;
                    state_d   = SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (req_valid[owner_q]) begin
                    req_ready[owner_q] = 1'b1;
                    data_d  = req_data[owner_q*DATA_W +: DATA_W];
                    last_d  = req_last[owner_q];
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant   = grant_q;
    assign tx_data = data_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int ACK_TIMEOUT = 8;
    localparam int FRAME       = 20;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        grant;
    logic                      tx_send;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_done;
    logic                      busy;
    logic                      err_retry;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_send   (tx_send),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .busy      (busy),
        .err_retry (err_retry)
    );

    typedef struct {
        logic [7:0] d;
        bit         last;
        int         gap;
    } byte_t;

    typedef struct {
        int         r;
        logic [7:0] d;
    } exp_t;

    byte_t src_q[NUM_REQ][$];
    byte_t stage_q[NUM_REQ][$];
    exp_t  exp_q[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   m_ptr = 0;
    int   n_accept = 0;
    int   n_send = 0;
    int   err_cnt = 0;
    int   send_cyc = 0;
    int   err_cyc = 0;
    int   retry_cyc = 0;
    int   ph_bytes = 0;
    int   ph_acc0 = 0;
    bit   ignore_next = 0;
    logic [7:0] cur_data = '0;
    bit   in_frame = 0;
    bit   frame_bad = 0;
    bit   retry_pend = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Requester sources: present the head byte after its gap; pop on accept.
    initial begin
        logic [NUM_REQ-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    n_accept++;
                end
                if (src_q[i].size() > 0) begin
                    byte_t t;
                    t = src_q[i][0];
                    if (t.gap > 0) begin
                        t.gap--;
                        src_q[i][0]  = t;
                        req_valid[i] = 1'b0;
                    end else begin
                        req_valid[i]          = 1'b1;
                        req_data[i*DATA_W +: DATA_W] = t.d;
                        req_last[i]           = t.last;
                    end
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Transmitter model: tx_done falls the cycle after tx_send, rises FRAME cycles later.
    initial begin
        bit s, r;
        int tx_cnt;
        tx_done = 1'b1;
        tx_cnt  = 0;
        forever begin
            @(negedge clk);
            s = tx_send;
            r = rst;
            @(posedge clk);
            #1;
            if (r) begin
                tx_done = 1'b1;
                tx_cnt  = 0;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) tx_done = 1'b1;
            end else if (s) begin
                if (ignore_next) begin
                    ignore_next = 0;
                end else begin
                    tx_done = 1'b0;
                    tx_cnt  = FRAME;
                end
            end
        end
    end

    // Monitor: pop expected bytes on each fresh tx_send, check retries, frame hold and ready rules.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame   = 0;
                frame_bad  = 0;
                retry_pend = 0;
            end else begin
                if (err_retry) begin
                    err_cnt++;
                    err_cyc    = cyc;
                    retry_pend = 1;
                end
                if (tx_send) begin
                    check("send_line_idle", 32'(tx_done), 32'd1);
                    if (retry_pend) begin
                        retry_pend = 0;
                        retry_cyc  = cyc;
                        check("retry_data", 32'(tx_data), 32'(cur_data));
                    end else if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_send: got tx_data %0h expected no send (cycle %0d)", tx_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", 32'(tx_data), 32'(e.d));
                        check("grant_at_send", 32'(grant), 32'(1) << e.r);
                        cur_data = e.d;
                        send_cyc = cyc;
                        n_send++;
                    end
                end
                if (tx_done == 1'b0) begin
                    in_frame = 1;
                    if (tx_data !== cur_data) frame_bad = 1;
                end else if (in_frame) begin
                    in_frame = 0;
                    check("frame_hold", 32'(frame_bad), 32'd0);
                    frame_bad = 0;
                end
                if (req_ready != '0) begin
                    check("ready_rule",
                          32'(((req_ready & ~req_valid) == '0) && $onehot(req_ready) && tx_done &&
                              (grant == '0 || (req_ready & ~grant) == '0)),
                          32'd1);
                end
            end
        end
    end

    task automatic add_byte(input int r, input logic [7:0] d, input int gap);
        byte_t t;
        t.d    = d;
        t.last = 0;
        t.gap  = gap;
        stage_q[r].push_back(t);
    endtask

    // Round-robin model: staged packets are all visible at once, so service
    // order is an upward wrap scan from the current pointer.
    task automatic commit();
        int start;
        start    = m_ptr;
        ph_bytes = 0;
        ph_acc0  = n_accept;
        for (int k = 0; k < NUM_REQ; k++) begin
            int r;
            r = (start + k) % NUM_REQ;
            if (stage_q[r].size() > 0) begin
                for (int b = 0; b < stage_q[r].size(); b++) begin
                    byte_t t;
                    exp_t  e;
                    t = stage_q[r][b];
                    if (b == stage_q[r].size() - 1) t.last = 1;
                    src_q[r].push_back(t);
                    e.r = r;
                    e.d = t.d;
                    exp_q.push_back(e);
                    ph_bytes++;
                end
                stage_q[r].delete();
                m_ptr = (r + 1) % NUM_REQ;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && src_empty()) break;
        end
        check({name, "_complete"}, 32'(k < 3000), 32'd1);
        check({name, "_accepts"}, 32'(n_accept - ph_acc0), 32'(ph_bytes));
        check({name, "_grant_free"}, 32'(grant), 32'd0);
    endtask

    task automatic wait_sends(input string name, input int target);
        int k;
        for (k = 0; k < 500 && n_send < target; k++) @(negedge clk);
        check({name, "_send_seen"}, 32'(n_send >= target), 32'd1);
    endtask

    task automatic wait_done_level(input string name, input logic lvl);
        int k;
        for (k = 0; k < 100 && tx_done !== lvl; k++) @(negedge clk);
        check(name, 32'(tx_done === lvl), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_ptr = 0;
    endtask

    // Global time bound.
    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion, required summary before time limit");
        $fatal(1);
    end

    initial begin
        int base;
        int e0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_retry", 32'(err_retry), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single two-byte packet from req0.
        add_byte(0, 8'h55, 0);
        add_byte(0, 8'hA3, 0);
        commit();
        wait_idle("single");

        // Pointer now 1: req1 beats req0.
        add_byte(0, 8'h10, 0);
        add_byte(1, 8'h11, 0);
        commit();
        wait_idle("ptr_after_single");

        pulse_reset();

        // Contention from ptr=0, then steer ptr to 2 and contend again.
        add_byte(0, 8'h20, 0);
        add_byte(2, 8'h22, 0);
        commit();
        wait_idle("contend_a");
        add_byte(1, 8'h31, 0);
        commit();
        wait_idle("steer");
        add_byte(0, 8'h40, 0);
        add_byte(2, 8'h42, 0);
        commit();
        wait_idle("contend_b");
        add_byte(0, 8'h50, 0);
        add_byte(2, 8'h52, 0);
        commit();
        wait_idle("contend_c");

        // Back-to-back bytes of one packet.
        for (int b = 1; b <= 4; b++) add_byte(0, 8'(b), 0);
        commit();
        wait_idle("b2b");

        // Packet lock: byte 2 arrives 10 idle cycles after byte 1's frame.
        base = n_send;
        add_byte(1, 8'hB1, 0);
        add_byte(1, 8'hB2, FRAME + 12);
        add_byte(1, 8'hB3, 0);
        add_byte(3, 8'hD3, 0);
        commit();
        wait_sends("lock", base + 1);
        wait_done_level("lock_frame_start", 1'b0);
        wait_done_level("lock_frame_end", 1'b1);
        repeat (3) @(negedge clk);
        check("lock_grant", 32'(grant), 32'b0010);
        check("lock_ready", 32'(req_ready), 32'd0);
        check("lock_req3_valid", 32'(req_valid[3]), 32'd1);
        check("lock_busy", 32'(busy), 32'd1);
        wait_idle("lock");

        // Ack timeout: the first send is ignored by the transmitter.
        e0 = err_cnt;
        ignore_next = 1;
        add_byte(0, 8'hC3, 0);
        commit();
        wait_idle("timeout");
        check("timeout_pulses", 32'(err_cnt - e0), 32'd1);
        check("timeout_delay", 32'(err_cyc - send_cyc), 32'(ACK_TIMEOUT));
        check("retry_delay", 32'(retry_cyc - err_cyc), 32'd1);

        // Reset in the middle of a frame.
        base = n_send;
        add_byte(2, 8'h7E, 0);
        commit();
        wait_sends("midrst", base + 1);
        repeat (5) @(negedge clk);
        check("midrst_in_frame", 32'({busy, tx_done}), 32'b10);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_tx_send", 32'(tx_send), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        wait_idle("midrst");
        add_byte(0, 8'h60, 0);
        add_byte(1, 8'h61, 0);
        commit();
        wait_idle("after_rst");

        // Randomized packet sets.
        for (int p = 0; p < 8; p++) begin
            int mask;
            mask = $urandom_range(1, 15);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (mask[r]) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        add_byte(r, 8'($urandom), (b == 0) ? 0 : $urandom_range(0, 3));
                    end
                end
            end
            commit();
            wait_idle("random");
        end

        check("err_total", 32'(err_cnt), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
